vdf_square_sequencer: RTL and testbench

VDF_SQUARE_SEQUENCER -- requirements
Module: vdf_square_sequencer

---
 rtl/vdf_seq_pkg.sv | 15 +
 rtl/seq_watchdog.sv | 31 +++
 rtl/vdf_square_sequencer.sv | 108 ++++++++++
 tb/tb_vdf_square_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vdf_seq_pkg.sv
// Shared types and default parameters for the VDF squaring sequencer.
package vdf_seq_pkg;

  localparam int unsigned ITER_WIDTH_DEFAULT = 64;
  localparam int unsigned TIMEOUT_DEFAULT    = 15;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDone,
    StError
  } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Saturating cycle counter that flags when TIMEOUT cycles have elapsed since the last clear.
module seq_watchdog
  import vdf_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // The clear lands in the issue cycle, which is the first counted cycle.
  localparam logic [CntW-1:0] Limit = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (cnt_q != Limit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == Limit);

endmodule

// File: rtl/vdf_square_sequencer.sv
// Issues T sequential squarings to an external datapath, with timeout, abort and done signalling.
module vdf_square_sequencer
  import vdf_seq_pkg::*;
#(
  parameter int unsigned ITER_WIDTH = ITER_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_in,
  input  logic [ITER_WIDTH-1:0] iterations_in,
  input  logic                  abort_in,
  input  logic                  dp_valid_in,
  output logic                  dp_go_out,
  output logic                  dp_load_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out,
  output logic [ITER_WIDTH-1:0] iter_count_out
);

  seq_state_e            state_q, state_d;
  logic [ITER_WIDTH-1:0] t_q, t_d;
  logic [ITER_WIDTH-1:0] count_q, count_d;
  logic                  error_q, error_d;
  logic                  go_q, load_q, busy_q, done_q;
  logic                  wd_clear, wd_expired;

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    count_d = count_q;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          count_d = '0;
          error_d = 1'b0;
          if (iterations_in != '0) begin
            t_d     = iterations_in;
            state_d = StIssue;
          end else begin
            state_d = StDone;
          end
        end
      end
      StIssue: begin
        state_d = abort_in ? StIdle : StWait;
      end
      StWait: begin
        if (abort_in) begin
          state_d = StIdle;
        end else if (dp_valid_in) begin
          count_d = count_q + ITER_WIDTH'(1);
          state_d = (count_d == t_q) ? StDone : StIssue;
        end else if (wd_expired) begin
          error_d = 1'b1;
          state_d = StError;
        end
      end
      StDone:  state_d = StIdle;
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign wd_clear = (state_d == StIssue);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      t_q     <= '0;
      count_q <= '0;
      error_q <= 1'b0;
      go_q    <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      count_q <= count_d;
      error_q <= error_d;
      go_q    <= (state_d == StIssue);
      load_q  <= (state_d == StIssue) && (count_d == '0);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
    end
  end

  seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .expired(wd_expired)
  );

  assign dp_go_out      = go_q;
  assign dp_load_out    = load_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign error_out      = error_q;
  assign iter_count_out = count_q;

endmodule

// File: tb/tb_vdf_square_sequencer.sv
// Self-checking bench: table of runs against a simple datapath model, plus a reset-mid-run sequence.
module tb_vdf_square_sequencer;

  localparam int unsigned IterWidth = 64;
  localparam int unsigned Timeout   = 15;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start_in;
  logic [IterWidth-1:0] iterations_in;
  logic                 abort_in;
  logic                 dp_valid_in;
  logic                 dp_go_out;
  logic                 dp_load_out;
  logic                 busy_out;
  logic                 done_out;
  logic                 error_out;
  logic [IterWidth-1:0] iter_count_out;

  vdf_square_sequencer #(
    .ITER_WIDTH(IterWidth),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_in      (start_in),
    .iterations_in (iterations_in),
    .abort_in      (abort_in),
    .dp_valid_in   (dp_valid_in),
    .dp_go_out     (dp_go_out),
    .dp_load_out   (dp_load_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .error_out     (error_out),
    .iter_count_out(iter_count_out)
  );

  always #5 clk = ~clk;

  // One run: T squarings, datapath latency L, optional abort cycle, and expected results.
  typedef struct {
    int t;
    int l;
    int abort_at;
    bit respond;
    int done_cyc;
    int count;
    int err_cyc;
    int n_go;
  } vec_t;

  typedef struct {
    int cyc;
    bit load;
  } go_t;

  vec_t vecs[10];
  go_t  exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_case(input int idx);
    vec_t v;
    int   cyc;
    int   pend;
    int   done_cyc;
    int   done_n;
    int   err_cyc;
    bit   fin;
    go_t  e;
    v = vecs[idx];
    exp_q.delete();
    for (int i = 0; i < v.n_go; i++) begin
      exp_q.push_back('{cyc: 1 + i * (v.l + 1), load: (i == 0)});
    end
    @(posedge clk); #1;
    start_in      = 1'b1;
    iterations_in = IterWidth'(v.t);
    pend     = -1;
    done_cyc = 0;
    done_n   = 0;
    err_cyc  = 0;
    fin      = 1'b0;
    cyc      = 0;
    while (!fin && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start_in    = 1'b0;
      dp_valid_in = 1'b0;
      abort_in    = 1'b0;
      if (cyc == 1) check($sformatf("v%0d busy_c1", idx), busy_out, 1);
      if (dp_go_out) begin
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d unexpected_go_cycle", idx), cyc, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d go_cycle", idx), cyc, e.cyc);
          check($sformatf("v%0d go_load", idx), dp_load_out, e.load);
        end
        if (v.respond) pend = cyc + v.l;
      end else if (dp_load_out) begin
        check($sformatf("v%0d load_without_go", idx), dp_load_out, 0);
      end
      if (done_out) begin
        done_n++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (error_out && err_cyc == 0) err_cyc = cyc;
      if (cyc == pend) dp_valid_in = 1'b1;
      if (cyc == v.abort_at) abort_in = 1'b1;
      if (!busy_out && cyc >= 2) fin = 1'b1;
    end
    dp_valid_in = 1'b0;
    abort_in    = 1'b0;
    check($sformatf("v%0d finished_in_budget", idx), fin, 1);
    check($sformatf("v%0d done_cycle", idx), done_cyc, v.done_cyc);
    check($sformatf("v%0d done_pulses", idx), done_n, (v.done_cyc != 0) ? 1 : 0);
    check($sformatf("v%0d iter_count", idx), iter_count_out, IterWidth'(v.count));
    check($sformatf("v%0d error_cycle", idx), err_cyc, v.err_cyc);
    check($sformatf("v%0d error_sticky", idx), error_out, (v.err_cyc != 0) ? 1 : 0);
    check($sformatf("v%0d missing_gos", idx), exp_q.size(), 0);
  endtask

  // Start T=3 with L=4, poke start_in during WAIT, then reset mid-run at cycle 7.
  task automatic reset_mid_run();
    int pend;
    pend = -1;
    @(posedge clk); #1;
    start_in      = 1'b1;
    iterations_in = IterWidth'(3);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk); #1;
      start_in    = 1'b0;
      dp_valid_in = 1'b0;
      reset       = 1'b0;
      if (dp_go_out) pend = cyc + 4;
      if (cyc == 1) check("rst_seq go_c1", {dp_go_out, dp_load_out}, 2'b11);
      if (cyc == 3) begin
        start_in      = 1'b1;
        iterations_in = IterWidth'(7);
      end
      if (cyc == 6) begin
        check("rst_seq go_c6", {dp_go_out, dp_load_out}, 2'b10);
        check("rst_seq count_c6", iter_count_out, 1);
      end
      if (cyc == 7) reset = 1'b1;
      if (cyc == 8) begin
        check("rst_seq outs_c8", {dp_go_out, dp_load_out, busy_out, done_out, error_out}, 5'b0);
        check("rst_seq count_c8", iter_count_out, 0);
      end
      if (cyc == 11) check("rst_seq idle_c11", {busy_out, done_out, dp_go_out}, 3'b0);
      if (cyc == pend) dp_valid_in = 1'b1;
    end
    dp_valid_in = 1'b0;
  endtask

  initial begin
    vecs[0] = '{t: 3, l: 4,  abort_at: 0, respond: 1, done_cyc: 16, count: 3, err_cyc: 0,  n_go: 3};
    vecs[1] = '{t: 0, l: 4,  abort_at: 0, respond: 1, done_cyc: 1,  count: 0, err_cyc: 0,  n_go: 0};
    vecs[2] = '{t: 2, l: 4,  abort_at: 0, respond: 0, done_cyc: 0,  count: 0, err_cyc: 16, n_go: 1};
    vecs[3] = '{t: 1, l: 1,  abort_at: 0, respond: 1, done_cyc: 3,  count: 1, err_cyc: 0,  n_go: 1};
    vecs[4] = '{t: 4, l: 2,  abort_at: 0, respond: 1, done_cyc: 13, count: 4, err_cyc: 0,  n_go: 4};
    vecs[5] = '{t: 5, l: 4,  abort_at: 8, respond: 1, done_cyc: 0,  count: 1, err_cyc: 0,  n_go: 2};
    vecs[6] = '{t: 2, l: 15, abort_at: 0, respond: 1, done_cyc: 0,  count: 0, err_cyc: 16, n_go: 1};
    vecs[7] = '{t: 2, l: 14, abort_at: 0, respond: 1, done_cyc: 31, count: 2, err_cyc: 0,  n_go: 2};
    vecs[8] = '{t: 3, l: 2,  abort_at: 4, respond: 1, done_cyc: 0,  count: 1, err_cyc: 0,  n_go: 2};
    vecs[9] = '{t: 3, l: 2,  abort_at: 3, respond: 1, done_cyc: 0,  count: 0, err_cyc: 0,  n_go: 1};

    reset         = 1'b1;
    start_in      = 1'b0;
    iterations_in = '0;
    abort_in      = 1'b0;
    dp_valid_in   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {dp_go_out, dp_load_out, busy_out, done_out, error_out}, 5'b0);
    check("reset_count", iter_count_out, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_case(i);
    reset_mid_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
